// File: rtl/xadc_drp_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : xadc_drp_sequencer_if
// Description : FPro MMIO slot bus bundle for the XADC DRP sequencer.
//               master = bus host (drives strobes/address/data),
//               slave  = slot core (returns rd_data).
//   cs       slot select
//   read     read strobe
//   write    write strobe
//   addr     5-bit register address
//   wr_data  32-bit write data
//   rd_data  32-bit read data (combinational in the slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface xadc_drp_sequencer_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (output cs, read, write, addr, wr_data, input rd_data);
    modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface
`default_nettype wire

// File: rtl/xadc_drp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : xadc_drp_sequencer
// Description : MMIO slot core that sweeps the enabled XADC channels over the
//               DRP on every end-of-conversion and keeps the results in a
//               per-channel sample register file.
//   clk        system clock
//   reset      asynchronous active-low reset
//   bus        slot bus (slave modport): cs/read/write/addr/wr_data/rd_data
//   eoc        XADC end-of-conversion pulse
//   drp_den    DRP enable (one-cycle pulse per read)
//   drp_dwe    DRP write enable (always 0)
//   drp_daddr  DRP address of the current/last read
//   drp_di     DRP write data (always 0)
//   drp_do     DRP read data
//   drp_drdy   DRP data ready
//   busy       sweep in progress
// Register map: 0 ctrl {mask[8+:N_CH], en[0]}; 1 status
//   {overrun, err_cnt[7:0], 7'b0, sweep_cnt[15:0]}; 8+i sample
//   {fresh, 15'b0, sample[15:0]}.
// Revision    : 1.0 - initial release
// ============================================================================
module xadc_drp_sequencer #(
    parameter int N_CH  = 6,
    parameter int TMO_W = 8
) (
    input  wire                  clk,
    input  wire                  reset,
    xadc_drp_sequencer_if.slave  bus,
    input  wire                  eoc,
    output logic                 drp_den,
    output logic                 drp_dwe,
    output logic [6:0]           drp_daddr,
    output logic [15:0]          drp_di,
    input  wire  [15:0]          drp_do,
    input  wire                  drp_drdy,
    output logic                 busy
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RDY = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Fixed XADC status-register addresses of the sequenced channels.
    function automatic logic [6:0] ch_daddr(input logic [CH_W-1:0] ch);
        case (int'(ch))
            0:       ch_daddr = 7'h00;
            1:       ch_daddr = 7'h01;
            2:       ch_daddr = 7'h13;
            3:       ch_daddr = 7'h1A;
            4:       ch_daddr = 7'h12;
            5:       ch_daddr = 7'h1B;
            default: ch_daddr = 7'h00;
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [6:0]              daddr_q, daddr_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic                    en_q, en_d;
    logic [N_CH-1:0]         mask_q, mask_d;
    logic [N_CH-1:0][15:0]   sample_q, sample_d;
    logic [N_CH-1:0]         fresh_q, fresh_d;
    logic [15:0]             sweep_cnt_q, sweep_cnt_d;
    logic [7:0]              err_cnt_q, err_cnt_d;
    logic                    overrun_q, overrun_d;

    logic                    nxt_found;
    logic [CH_W-1:0]         nxt_idx;
    logic                    txn_end;
    logic [31:0]             rd_mux;
    logic                    unused_wr_bits;

    // Only a few write-data bits are architected; fold the rest away.
    assign unused_wr_bits = ^bus.wr_data;

    // Lowest enabled channel: from 0 when starting a sweep, strictly above
    // the current channel while a sweep is running. Uses the live mask so
    // mid-sweep mask writes apply at the next selection.
    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && ((state_q == IDLE) || (i > int'(ch_q)))) begin
                nxt_found = 1'b1;
                nxt_idx   = CH_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        daddr_d     = daddr_q;
        tmo_d       = tmo_q;
        en_d        = en_q;
        mask_d      = mask_q;
        sample_d    = sample_q;
        fresh_d     = fresh_q;
        sweep_cnt_d = sweep_cnt_q;
        err_cnt_d   = err_cnt_q;
        overrun_d   = overrun_q;
        txn_end     = 1'b0;

        // Software read clears fresh; a same-cycle drdy store below re-sets it.
        for (int i = 0; i < N_CH; i++) begin
            if (bus.cs && bus.read && (bus.addr == 5'(8 + i))) begin
                fresh_d[i] = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                if (eoc && en_q && nxt_found) begin
                    state_d = ISSUE;
                    ch_d    = nxt_idx;
                    daddr_d = ch_daddr(nxt_idx);
                end
            end
            ISSUE: begin
                state_d = WAIT_RDY;
                tmo_d   = '0;
            end
            WAIT_RDY: begin
                if (drp_drdy) begin
                    sample_d[ch_q] = drp_do;
                    fresh_d[ch_q]  = 1'b1;
                    txn_end        = 1'b1;
                end else if (tmo_q == {TMO_W{1'b1}}) begin
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    txn_end = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
                // The outstanding read always finishes before enable is honoured.
                if (txn_end) begin
                    if (en_q && nxt_found) begin
                        state_d = ISSUE;
                        ch_d    = nxt_idx;
                        daddr_d = ch_daddr(nxt_idx);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                sweep_cnt_d = sweep_cnt_q + 16'd1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (eoc && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        // Status clear has priority over a same-cycle error increment.
        if (bus.cs && bus.write && (bus.addr == 5'd1) && bus.wr_data[0]) begin
            err_cnt_d = 8'd0;
            overrun_d = 1'b0;
        end

        if (bus.cs && bus.write && (bus.addr == 5'd0)) begin
            en_d   = bus.wr_data[0];
            mask_d = bus.wr_data[8 +: N_CH];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            daddr_q     <= '0;
            tmo_q       <= '0;
            en_q        <= 1'b0;
            mask_q      <= '0;
            sample_q    <= '0;
            fresh_q     <= '0;
            sweep_cnt_q <= '0;
            err_cnt_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            daddr_q     <= daddr_d;
            tmo_q       <= tmo_d;
            en_q        <= en_d;
            mask_q      <= mask_d;
            sample_q    <= sample_d;
            fresh_q     <= fresh_d;
            sweep_cnt_q <= sweep_cnt_d;
            err_cnt_q   <= err_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        if (bus.addr == 5'd0) begin
            rd_mux[0]        = en_q;
            rd_mux[8 +: N_CH] = mask_q;
        end else if (bus.addr == 5'd1) begin
            rd_mux = {overrun_q, err_cnt_q, 7'd0, sweep_cnt_q};
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.addr == 5'(8 + i)) begin
                    rd_mux = {fresh_q[i], 15'd0, sample_q[i]};
                end
            end
        end
    end

    assign bus.rd_data = rd_mux;
    assign drp_den     = (state_q == ISSUE);
    assign drp_dwe     = 1'b0;
    assign drp_di      = 16'd0;
    assign drp_daddr   = daddr_q;
    assign busy        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_xadc_drp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_xadc_drp_sequencer
// Description : Self-checking bench for xadc_drp_sequencer. A transaction-
//               level reference model tracks the sweep and register file; a
//               DRP responder answers den pulses after 1-3 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xadc_drp_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        eoc = 1'b0;
    logic        drp_den, drp_dwe, busy;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic [15:0] drp_do = 16'd0;
    logic        drp_drdy = 1'b0;

    always #5 clk = ~clk;

    xadc_drp_sequencer_if bus ();

    xadc_drp_sequencer #(.N_CH(6), .TMO_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .eoc       (eoc),
        .drp_den   (drp_den),
        .drp_dwe   (drp_dwe),
        .drp_daddr (drp_daddr),
        .drp_di    (drp_di),
        .drp_do    (drp_do),
        .drp_drdy  (drp_drdy),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [6:0]  tbl [6] = '{7'h00, 7'h01, 7'h13, 7'h1A, 7'h12, 7'h1B};
    bit          m_en;
    logic [5:0]  m_mask;
    logic [15:0] m_sample [6];
    bit          m_fresh [6];
    int          m_sweep, m_err;
    bit          m_ovr;
    bit          m_busy, m_den, m_done;
    int          m_ch, m_waited;
    logic [6:0]  m_daddr;

    function automatic int first_from(input logic [5:0] mk, input int s);
        for (int i = s; i < 6; i++) if (mk[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        int k;
        k = int'(a) - 8;
        if (a == 5'd0) return {18'd0, m_mask, 7'd0, m_en};
        if (a == 5'd1) return {m_ovr, 8'(m_err), 7'd0, 16'(m_sweep)};
        if (k >= 0 && k < 6) return {m_fresh[k], 15'd0, m_sample[k]};
        return 32'd0;
    endfunction

    always @(posedge clk or negedge reset) begin
        int a, n;
        bit fin, en_now;
        logic [5:0] mk;
        if (!reset) begin
            m_en = 0; m_mask = '0; m_sweep = 0; m_err = 0; m_ovr = 0;
            m_busy = 0; m_den = 0; m_done = 0; m_ch = 0; m_waited = 0; m_daddr = '0;
            for (int i = 0; i < 6; i++) begin m_sample[i] = '0; m_fresh[i] = 0; end
        end else begin
            en_now = m_en;
            mk     = m_mask;
            a      = int'(bus.addr);
            if (bus.cs && bus.read && a >= 8 && a < 14) m_fresh[a-8] = 0;
            if (!m_busy) begin
                n = first_from(mk, 0);
                if (eoc && en_now && n >= 0) begin
                    m_busy = 1; m_den = 1; m_ch = n; m_daddr = tbl[n];
                end
            end else begin
                if (eoc) m_ovr = 1;
                if (m_done) begin
                    m_done = 0; m_busy = 0; m_sweep = (m_sweep + 1) % 65536;
                end else if (m_den) begin
                    m_den = 0; m_waited = 0;
                end else begin
                    fin = 0;
                    if (drp_drdy) begin
                        m_sample[m_ch] = drp_do; m_fresh[m_ch] = 1; fin = 1;
                    end else if (m_waited == 255) begin
                        if (m_err < 255) m_err++;
                        fin = 1;
                    end else begin
                        m_waited++;
                    end
                    if (fin) begin
                        n = first_from(mk, m_ch + 1);
                        if (n >= 0 && en_now) begin
                            m_den = 1; m_ch = n; m_daddr = tbl[n];
                        end else begin
                            m_done = 1;
                        end
                    end
                end
            end
            if (bus.cs && bus.write && a == 1 && bus.wr_data[0]) begin m_err = 0; m_ovr = 0; end
            if (bus.cs && bus.write && a == 0) begin m_en = bus.wr_data[0]; m_mask = bus.wr_data[13:8]; end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk("den",     {31'd0, drp_den}, {31'd0, m_den});
        chk("busy",    {31'd0, busy},    {31'd0, m_busy});
        chk("daddr",   {25'd0, drp_daddr}, {25'd0, m_daddr});
        chk("dwe",     {31'd0, drp_dwe}, 32'd0);
        chk("di",      {16'd0, drp_di},  32'd0);
        chk("rd_data", bus.rd_data, model_rd(bus.addr));
    end

    // ------------------------------------------------------------------
    // DRP responder and den monitor
    // ------------------------------------------------------------------
    logic [6:0]  den_q [$];
    bit          drop_en = 0;
    logic [6:0]  drop_addr = 7'h00;
    bit          force_en = 0;
    bit          stray_req = 0;
    int          rsp_fixed = 0;
    int          rsp_wait = 0;
    logic [15:0] rsp_val = 16'd0;

    always @(negedge clk) begin
        if (drp_den) begin
            den_q.push_back(drp_daddr);
            if (!(drop_en && drp_daddr == drop_addr)) begin
                rsp_wait = (rsp_fixed > 0) ? rsp_fixed : int'($urandom_range(1, 3));
                rsp_val  = (force_en && drp_daddr == 7'h1B) ? 16'hABC0 : 16'($urandom);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        drp_drdy = 1'b0;
        if (rsp_wait > 0) begin
            rsp_wait--;
            if (rsp_wait == 0) begin drp_drdy = 1'b1; drp_do = rsp_val; end
        end
        if (stray_req) begin
            drp_drdy = 1'b1; drp_do = 16'($urandom); stray_req = 0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        bus.cs = 1; bus.write = 1; bus.addr = a; bus.wr_data = d;
        tick();
        bus.cs = 0; bus.write = 0;
    endtask

    task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
        bus.cs = 1; bus.read = 1; bus.addr = a;
        @(negedge clk);
        d = bus.rd_data;
        tick();
        bus.cs = 0; bus.read = 0;
    endtask

    task automatic pulse_eoc();
        eoc = 1; tick(); eoc = 0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin tick(); k++; end
        chk("idle_within_budget", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_den(input int n, input int budget);
        int k;
        k = 0;
        while (den_q.size() < n && k < budget) begin tick(); k++; end
        chk("den_seen_within_budget", {31'd0, den_q.size() >= n}, 32'd1);
    endtask

    function automatic logic [31:0] rnd_ctrl();
        return {18'd0, 6'($urandom), 7'd0, ($urandom_range(0, 7) != 0)};
    endfunction

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] d;
        logic [6:0]  exp_full [6];
        exp_full = '{7'h00, 7'h01, 7'h13, 7'h1A, 7'h12, 7'h1B};

        bus.cs = 0; bus.read = 0; bus.write = 0; bus.addr = '0; bus.wr_data = '0;
        reset = 1;
        #1 reset = 0;
        repeat (3) tick();
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_den",  {31'd0, drp_den}, 32'd0);
        reset = 1;
        tick();
        bus_rd(5'd1, d); chk("reset_status", d, 32'd0);
        bus_rd(5'd8, d); chk("reset_sample0", d, 32'd0);

        // Full six-channel sweep.
        bus_wr(5'd0, 32'h3F01);
        bus_rd(5'd0, d); chk("ctrl_readback", d, 32'h0000_3F01);
        den_q.delete();
        pulse_eoc();
        wait_idle(200);
        chk("full_den_count", den_q.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < den_q.size()) chk("full_daddr", {25'd0, den_q[i]}, {25'd0, exp_full[i]});
        end
        bus_rd(5'd1, d); chk("sweep_after_1", d, 32'h0000_0001);
        for (int i = 0; i < 6; i++) begin
            bus_rd(5'(8 + i), d); chk("fresh_after_sweep", {31'd0, d[31]}, 32'd1);
        end

        // Sparse mask, forced data on ch5, fresh-on-read.
        force_en = 1;
        bus_wr(5'd0, 32'h2401);
        den_q.delete();
        pulse_eoc();
        wait_idle(200);
        chk("sparse_den_count", den_q.size(), 32'd2);
        if (den_q.size() == 2) begin
            chk("sparse_daddr0", {25'd0, den_q[0]}, 32'h13);
            chk("sparse_daddr1", {25'd0, den_q[1]}, 32'h1B);
        end
        bus_rd(5'd13, d); chk("ch5_first_read", d, 32'h8000_ABC0);
        bus_rd(5'd13, d); chk("ch5_second_read", d, 32'h0000_ABC0);
        force_en = 0;

        // Timeout on ch1.
        drop_en = 1; drop_addr = 7'h01;
        bus_wr(5'd0, 32'h3F01);
        den_q.delete();
        pulse_eoc();
        wait_idle(2000);
        chk("timeout_den_count", den_q.size(), 32'd6);
        bus_rd(5'd1, d); chk("timeout_status", d, 32'h0080_0003);
        drop_en = 0;
        bus_wr(5'd1, 32'h1);
        bus_rd(5'd1, d); chk("status_cleared", d, 32'h0000_0003);

        // eoc while busy: overrun, no restart.
        pulse_eoc();
        repeat (5) tick();
        pulse_eoc();
        wait_idle(200);
        bus_rd(5'd1, d); chk("overrun_status", d, 32'h8000_0004);

        // Clear enable during WAIT_RDY of ch1.
        rsp_fixed = 3;
        den_q.delete();
        pulse_eoc();
        wait_den(2, 50);
        bus_wr(5'd0, 32'h3F00);
        wait_idle(50);
        chk("abort_den_count", den_q.size(), 32'd2);
        bus_rd(5'd1, d); chk("abort_status", d, 32'h8000_0005);
        rsp_fixed = 0;

        // Randomized sweeps.
        for (int it = 0; it < 30; it++) begin
            drop_en   = ($urandom_range(0, 7) == 0);
            drop_addr = tbl[$urandom_range(0, 5)];
            bus_wr(5'd0, rnd_ctrl());
            pulse_eoc();
            repeat ($urandom_range(0, 10)) begin
                case ($urandom_range(0, 4))
                    0: bus_rd(5'($urandom_range(0, 15)), d);
                    1: bus_wr(5'd0, rnd_ctrl());
                    2: begin stray_req = 1; tick(); end
                    3: pulse_eoc();
                    default: bus_wr(5'd1, 32'($urandom_range(0, 1)));
                endcase
            end
            wait_idle(2000);
            stray_req = 1; tick();
            for (int i = 8; i < 14; i++) bus_rd(5'(i), d);
        end
        drop_en = 0;

        // Asynchronous reset during WAIT_RDY.
        bus_wr(5'd0, 32'h3F01);
        rsp_fixed = 3;
        bus.addr = 5'd1;
        den_q.delete();
        pulse_eoc();
        wait_den(1, 20);
        #1 reset = 0;
        #1;
        chk("async_reset_busy", {31'd0, busy}, 32'd0);
        chk("async_reset_den", {31'd0, drp_den}, 32'd0);
        chk("async_reset_status", bus.rd_data, 32'd0);
        #1 reset = 1;
        repeat (6) tick();
        rsp_fixed = 0;
        bus_rd(5'd8, d); chk("post_reset_sample0", d, 32'd0);
        bus_rd(5'd0, d); chk("post_reset_ctrl", d, 32'd0);
        bus_rd(5'd1, d); chk("post_reset_status", d, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
